dendrite_accum: RTL

- Consumer end of the dendrite fire channel. Accepts (address, signed 9-bit charge) fires from the dendrite mux over valid/ready.
- Accumulates each fire into a per-neuron signed charge store, with saturating arithmetic and read-after-write forwarding.
- On a step request, drains every non-zero accumulator to the neuron unit over a second valid/ready channel. Each drained location is cleared.
- Sits between the dendrite mux and the neuron update logic.

---
 rtl/dendrite_accum.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dendrite_accum.sv
// Per-neuron signed charge accumulator: absorbs dendrite fires with saturation
// and forwarding, and drains non-zero entries to the neuron unit on a step request.
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | zero one RAM entry per cycle after reset
// ACCUM | accept fires, read-modify-write into the charge store
// FLUSH | let the last accumulate write land, read address 0
// DRAIN | scan all entries, emit and clear the non-zero ones
// DONE  | one-cycle step_done, then back to ACCUM or into a pending drain
module dendrite_accum #(
  parameter int NUM_NEURONS = 256,
  parameter int ADDR_W      = 8,
  parameter int ACC_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] dend_addr,
  input  logic [8:0]        dend_charge,
  input  logic              dend_vld,
  output logic              dend_rdy,
  input  logic              step_start,
  output logic              step_done,
  output logic              busy,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ACC_W-1:0]  out_charge,
  output logic              out_vld,
  input  logic              out_rdy
);

  typedef enum logic [2:0] {S_CLEAR, S_ACCUM, S_FLUSH, S_DRAIN, S_DONE} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NEURONS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [ADDR_W-1:0] scan_q, scan_d;
  logic              pend_q, pend_d;

  logic              s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [8:0]        s1_chg_q;
  logic              wb_vld_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [ACC_W-1:0]  wb_data_q;

  logic [ACC_W-1:0]  mem_q [NUM_NEURONS];
  logic [ACC_W-1:0]  rdata_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa, ram_ra;
  logic [ACC_W-1:0]  ram_wd;

  logic              start_req, in_range;
  logic [ACC_W-1:0]  acc_old, sum_sat;
  logic [ACC_W:0]    sum_wide;

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_wa] <= ram_wd;
    rdata_q <= mem_q[ram_ra];
  end

  assign start_req = pend_q | step_start;
  assign in_range  = ({1'b0, dend_addr} < (ADDR_W+1)'(NUM_NEURONS));
  assign s1_vld_d  = dend_vld && dend_rdy && in_range;

  // The RAM returns pre-write data when the previous fire hit the same entry.
  assign acc_old  = (wb_vld_q && (wb_addr_q == s1_addr_q)) ? wb_data_q : rdata_q;
  assign sum_wide = {acc_old[ACC_W-1], acc_old} + {{(ACC_W-8){s1_chg_q[8]}}, s1_chg_q};

  always_comb begin
    sum_sat = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
      sum_sat = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    scan_d    = scan_q;
    pend_d    = start_req;
    dend_rdy  = 1'b0;
    out_vld   = 1'b0;
    busy      = 1'b0;
    step_done = 1'b0;
    ram_we    = 1'b0;
    ram_wa    = '0;
    ram_wd    = '0;
    ram_ra    = '0;
    case (state_q)
      S_CLEAR: begin
        busy   = 1'b1;
        ram_we = 1'b1;
        ram_wa = clr_q;
        clr_d  = clr_q + 1'b1;
        if (clr_q == LAST) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        ram_ra = dend_addr;
        if (s1_vld_q) begin
          ram_we = 1'b1;
          ram_wa = s1_addr_q;
          ram_wd = sum_sat;
        end
        if (start_req) begin
          state_d = S_FLUSH;
          pend_d  = 1'b0;
        end else begin
          dend_rdy = 1'b1;
        end
      end
      S_FLUSH: begin
        busy    = 1'b1;
        scan_d  = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        out_vld = (rdata_q != '0);
        // While stalled the same entry is re-read so the output stays put.
        if (!out_vld || out_rdy) begin
          ram_we = out_vld;
          ram_wa = scan_q;
          ram_ra = scan_q + 1'b1;
          scan_d = scan_q + 1'b1;
          if (scan_q == LAST) state_d = S_DONE;
        end else begin
          ram_ra = scan_q;
        end
      end
      S_DONE: begin
        step_done = 1'b1;
        if (start_req) begin
          state_d = S_FLUSH;
          pend_d  = 1'b0;
        end else begin
          state_d = S_ACCUM;
        end
      end
      default: state_d = S_CLEAR;
    endcase
    out_addr   = out_vld ? scan_q : '0;
    out_charge = out_vld ? rdata_q : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_CLEAR;
      clr_q     <= '0;
      scan_q    <= '0;
      pend_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_chg_q  <= '0;
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      scan_q    <= scan_d;
      pend_q    <= pend_d;
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= dend_addr;
      s1_chg_q  <= dend_charge;
      wb_vld_q  <= s1_vld_q;
      wb_addr_q <= s1_addr_q;
      wb_data_q <= sum_sat;
    end
  end

endmodule
